udp_reply_tx: RTL and testbench
===============================

// Module: udp_reply_tx
// PURPOSE
//  Transmit-side counterpart of the UDP command receive path. Detects read/write completion
//  from the SDRAM/SD transfer logic and builds a fixed 8-byte reply packet: header, event type,
//  echoed 32-bit command word, sequence number, XOR checksum. Streams the packet into the UDP
//  stack transmit interface with a request/ack handshake, so the host learns the command finished.
// PARAMETERS
//  HDR_BYTE     8'hAA   value of reply byte 0
//  ACK_TIMEOUT  1000    max cycles in REQ waiting for app_tx_ack before abandoning the attempt
//  GAP_CYCLES   4       idle cycles forced after each packet before the next request
// PORTS
//  udp_tx_clk          in   1   single clock
//  reset               in   1   synchronous, active-low reset
//  read_finish         in   1   read done level/pulse, may be asynchronous; 2-flop synced inside
//  write_finish        in   1   write done level/pulse, may be asynchronous; 2-flop synced inside
//  cmd_word            in   32  command word being executed (bytes 2..5 of received cmd)
//  app_tx_ready        in   1   UDP stack can accept a new packet request
//  app_tx_ack          in   1   UDP stack grants the request; data starts next cycle
//  app_tx_data_request out  1   packet request to UDP stack
//  app_tx_data_valid   out  1   byte strobe
//  app_tx_data         out  8   reply byte
//  udp_data_length     out  16  constant 16'd8, payload length of reply
//  busy                out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): all outputs 0 except udp_data_length=8; FSM=IDLE;
//    sync flops, pending flags, seq counter (8 bit) cleared. Reset mid-packet aborts immediately,
//    no further valid bytes, pending events are lost.
//  - Event detect: rising edge of synced finish (sync2 & ~sync3). Each edge sets pend_rd or
//    pend_wr. Flags clear only when captured into a packet (LATCH). An edge arriving in the
//    same cycle as capture stays set (set wins over clear for a new event).
//  - Edge detection latency: finish input to pend flag = 3 clocks.
//  - FSM states: IDLE, LATCH, REQ, SEND, GAP.
//  - IDLE: if (pend_rd|pend_wr) & app_tx_ready -> LATCH.
//  - LATCH (1 cycle): snapshot type = {6'b0, pend_wr, pend_rd} (01 read, 02 write, 03 both),
//    snapshot cmd_word and seq; clear captured flags -> REQ.
//  - REQ: app_tx_data_request=1. On app_tx_ack -> SEND, byte index=0. If ACK_TIMEOUT cycles
//    elapse without ack: drop request, restore snapshot flags into pend_rd/pend_wr (OR with any
//    new edges), seq unchanged -> GAP.
//  - SEND: app_tx_data_valid=1 for exactly 8 consecutive cycles, MSB-first:
//    b0=HDR_BYTE, b1=type, b2=cmd[31:24], b3=cmd[23:16], b4=cmd[15:8], b5=cmd[7:0], b6=seq,
//    b7=XOR(b0..b6). First byte one cycle after ack. After b7: seq<=seq+1 (wraps 255->0) -> GAP.
//  - GAP: outputs idle for GAP_CYCLES cycles -> IDLE. GAP_CYCLES=0 means GAP lasts 1 cycle.
//  - app_tx_data is 0 whenever app_tx_data_valid is 0. app_tx_ack outside REQ is ignored.
//  - cmd_word changes after LATCH do not affect the packet in flight.
//  - Multiple edges of one type before capture collapse into one report.
// TESTING
//  1 read_finish pulse, cmd_word=32'h12345678, ready=1, ack 2 cycles after request ->
//    bytes AA 01 12 34 56 78 00 chk (XOR), valid 8 cycles, seq becomes 1.
//  2 read_finish and write_finish rising same cycle -> single packet, type byte 03.
//  3 write_finish edge during SEND of a read packet -> second packet type 02 after GAP,
//    seq incremented by one.
//  4 ack withheld for ACK_TIMEOUT cycles -> request drops, retry issues same type/seq;
//    ack on retry sends packet normally.
//  5 send 256 packets -> seq byte runs 00..FF then wraps to 00 on packet 257.
//  6 assert reset at byte 4 of SEND -> valid low next cycle, request 0, no packet on release.

Source files
------------

// File: rtl/udp_reply_tx.sv
// Reply packet builder: turns synced read/write completion edges into an 8-byte
// status packet streamed to the UDP stack over a request/ack handshake.
module udp_reply_tx #(
  parameter logic [7:0] HDR_BYTE    = 8'hAA,
  parameter int         ACK_TIMEOUT = 1000,
  parameter int         GAP_CYCLES  = 4
) (
  input  logic        udp_tx_clk,
  input  logic        reset,
  input  logic        read_finish,
  input  logic        write_finish,
  input  logic [31:0] cmd_word,
  input  logic        app_tx_ready,
  input  logic        app_tx_ack,
  output logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  function automatic logic [7:0] xor_sum(input logic [7:0] typ, input logic [31:0] cmd,
                                         input logic [7:0] seq);
    return HDR_BYTE ^ typ ^ cmd[31:24] ^ cmd[23:16] ^ cmd[15:8] ^ cmd[7:0] ^ seq;
  endfunction

  function automatic logic [7:0] reply_byte(input logic [2:0] idx, input logic [7:0] typ,
                                            input logic [31:0] cmd, input logic [7:0] seq);
    case (idx)
      3'd0:    return HDR_BYTE;
      3'd1:    return typ;
      3'd2:    return cmd[31:24];
      3'd3:    return cmd[23:16];
      3'd4:    return cmd[15:8];
      3'd5:    return cmd[7:0];
      3'd6:    return seq;
      3'd7:    return xor_sum(typ, cmd, seq);
      default: return 8'h00;
    endcase
  endfunction

  logic [2:0]  rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d;
  logic        pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  type_q, type_d;
  logic [31:0] cmd_q, cmd_d;
  logic [7:0]  seq_q, seq_d;
  logic        req_q, req_d, valid_q, valid_d, busy_q, busy_d;
  logic [7:0]  data_q, data_d;
  logic        rise_rd_s, rise_wr_s, clr_s, restore_rd_s, restore_wr_s;

  // Next-state, event bookkeeping and registered output decode.
  always_comb begin
    rd_sync_d    = {rd_sync_q[1:0], read_finish};
    wr_sync_d    = {wr_sync_q[1:0], write_finish};
    rise_rd_s    = rd_sync_q[1] & ~rd_sync_q[2];
    rise_wr_s    = wr_sync_q[1] & ~wr_sync_q[2];
    state_d      = state_q;
    timer_d      = 16'd0;
    idx_d        = idx_q;
    type_d       = type_q;
    cmd_d        = cmd_q;
    seq_d        = seq_q;
    clr_s        = 1'b0;
    restore_rd_s = 1'b0;
    restore_wr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((pend_rd_q | pend_wr_q) & app_tx_ready) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        type_d  = {6'b000000, pend_wr_q, pend_rd_q};
        cmd_d   = cmd_word;
        clr_s   = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (app_tx_ack) begin
          state_d = ST_SEND;
          idx_d   = 3'd0;
        end else if (timer_q == ACK_LAST) begin
          // Abandoned attempt: hand the captured events back for a retry.
          state_d      = ST_GAP;
          restore_rd_s = type_q[0];
          restore_wr_s = type_q[1];
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_SEND: begin
        if (idx_q == 3'd7) begin
          state_d = ST_GAP;
          seq_d   = seq_q + 8'd1;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pend_rd_d = (pend_rd_q & ~clr_s) | rise_rd_s | restore_rd_s;
    pend_wr_d = (pend_wr_q & ~clr_s) | rise_wr_s | restore_wr_s;
    req_d     = (state_d == ST_REQ);
    valid_d   = (state_d == ST_SEND);
    busy_d    = (state_d != ST_IDLE);
    if (valid_d) begin
      data_d = reply_byte(idx_d, type_d, cmd_d, seq_q);
    end else begin
      data_d = 8'h00;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge udp_tx_clk) begin
    if (!reset) begin
      rd_sync_q <= 3'b000;
      wr_sync_q <= 3'b000;
      pend_rd_q <= 1'b0;
      pend_wr_q <= 1'b0;
      state_q   <= ST_IDLE;
      timer_q   <= 16'd0;
      idx_q     <= 3'd0;
      type_q    <= 8'h00;
      cmd_q     <= 32'h0000_0000;
      seq_q     <= 8'h00;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      rd_sync_q <= rd_sync_d;
      wr_sync_q <= wr_sync_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      type_q    <= type_d;
      cmd_q     <= cmd_d;
      seq_q     <= seq_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
    end
  end

  assign app_tx_data_request = req_q;
  assign app_tx_data_valid   = valid_q;
  assign app_tx_data         = data_q;
  assign busy                = busy_q;
  assign udp_data_length     = 16'd8;

endmodule

// File: tb/tb_udp_reply_tx.sv
// Directed + randomized bench for udp_reply_tx; expected packets come from a
// byte-list model of the reply format and a bench-side sequence counter.
module tb_udp_reply_tx;
  logic        clk = 1'b0;
  logic        rst_n, read_finish, write_finish, app_tx_ready, app_tx_ack;
  logic [31:0] cmd_word;
  logic        app_tx_data_request, app_tx_data_valid, busy;
  logic [7:0]  app_tx_data;
  logic [15:0] udp_data_length;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] seq_m    = 8'h00;

  always #5 clk = ~clk;

  udp_reply_tx dut (
    .udp_tx_clk(clk), .reset(rst_n), .read_finish(read_finish), .write_finish(write_finish),
    .cmd_word(cmd_word), .app_tx_ready(app_tx_ready), .app_tx_ack(app_tx_ack),
    .app_tx_data_request(app_tx_data_request), .app_tx_data_valid(app_tx_data_valid),
    .app_tx_data(app_tx_data), .udp_data_length(udp_data_length), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] typ,
                                          input logic [31:0] cmd, input logic [7:0] seq);
    logic [7:0] p [8];
    p[0] = 8'hAA; p[1] = typ;
    p[2] = cmd[31:24]; p[3] = cmd[23:16]; p[4] = cmd[15:8]; p[5] = cmd[7:0];
    p[6] = seq; p[7] = 8'h00;
    for (int k = 0; k < 7; k++) p[7] = p[7] ^ p[k];
    return p[i];
  endfunction

  task automatic pulse(input logic rd, input logic wr);
    @(negedge clk); read_finish = rd; write_finish = wr;
    @(negedge clk); read_finish = 1'b0; write_finish = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (app_tx_data_request !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("req_seen", {31'd0, app_tx_data_request}, 32'd1);
  endtask

  task automatic run_packet(input logic [7:0] typ, input logic [31:0] cmd,
                            input int ack_dly, input int wr_at);
    wait_req();
    cmd_word = $urandom;
    repeat (ack_dly) @(negedge clk);
    chk("req_hold", {31'd0, app_tx_data_request}, 32'd1);
    chk("valid_pre", {31'd0, app_tx_data_valid}, 32'd0);
    app_tx_ack = 1'b1;
    @(negedge clk);
    app_tx_ack = 1'b0;
    chk("req_after_ack", {31'd0, app_tx_data_request}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("valid%0d", i), {31'd0, app_tx_data_valid}, 32'd1);
      chk($sformatf("byte%0d", i), {24'd0, app_tx_data}, {24'd0, exp_byte(i, typ, cmd, seq_m)});
      write_finish = (i == wr_at);
      @(negedge clk);
    end
    write_finish = 1'b0;
    chk("valid_post", {31'd0, app_tx_data_valid}, 32'd0);
    chk("data_post", {24'd0, app_tx_data}, 32'd0);
    seq_m = seq_m + 8'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] typ;
    int         cnt;
    logic       seen;
    rst_n = 1'b0; read_finish = 1'b0; write_finish = 1'b0;
    app_tx_ready = 1'b1; app_tx_ack = 1'b0; cmd_word = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, app_tx_data_request}, 32'd0);
    chk("rst_valid", {31'd0, app_tx_data_valid}, 32'd0);
    chk("rst_data", {24'd0, app_tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_len", {16'd0, udp_data_length}, 32'd8);
    rst_n = 1'b1;

    // ack while idle is ignored
    @(negedge clk); app_tx_ack = 1'b1;
    @(negedge clk); @(negedge clk); app_tx_ack = 1'b0;
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack_req", {31'd0, app_tx_data_request}, 32'd0);

    // test 1: single read, three-clock edge latency, then LATCH
    cmd_word = 32'h12345678;
    @(negedge clk); read_finish = 1'b1;
    @(negedge clk); read_finish = 1'b0;
    chk("lat_e1", {31'd0, busy}, 32'd0);
    @(negedge clk); chk("lat_e2", {31'd0, busy}, 32'd0);
    @(negedge clk); chk("lat_e3", {31'd0, busy}, 32'd0);
    @(negedge clk); chk("lat_e4", {31'd0, busy}, 32'd1);
    run_packet(8'h01, 32'h12345678, 2, -1);

    // test 2: both edges together while not ready -> one type 03 packet
    app_tx_ready = 1'b0;
    cmd_word = $urandom;
    pulse(1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("not_ready_busy", {31'd0, busy}, 32'd0);
    app_tx_ready = 1'b1;
    run_packet(8'h03, cmd_word, $urandom_range(0, 4), -1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (app_tx_data_request === 1'b1) seen = 1'b1;
    end
    chk("no_dup_packet", {31'd0, seen}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // test 3: write edge during read SEND -> follow-up type 02 packet
    cmd_word = $urandom;
    pulse(1'b1, 1'b0);
    run_packet(8'h01, cmd_word, $urandom_range(0, 3), 3);
    run_packet(8'h02, cmd_word, $urandom_range(0, 3), -1);

    // test 4: ack withheld -> request drops after the timeout, retry same type/seq
    cmd_word = $urandom;
    pulse(1'b1, 1'b0);
    wait_req();
    cnt = 0;
    while (app_tx_data_request === 1'b1 && cnt < 1100) begin
      @(negedge clk); cnt++;
    end
    chk("timeout_len", cnt, 32'd1000);
    chk("timeout_valid", {31'd0, app_tx_data_valid}, 32'd0);
    run_packet(8'h01, cmd_word, 1, -1);

    // test 5: 256 random packets, seq wraps through FF -> 00
    for (int p = 0; p < 256; p++) begin
      typ = 8'($urandom_range(1, 3));
      cmd_word = $urandom;
      pulse(typ[0], typ[1]);
      run_packet(typ, cmd_word, $urandom_range(0, 3), -1);
    end

    // test 6: reset at byte 4 of SEND kills the packet and pending events
    cmd_word = $urandom;
    pulse(1'b1, 1'b0);
    wait_req();
    app_tx_ack = 1'b1;
    @(negedge clk); app_tx_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_byte4", {24'd0, app_tx_data}, {24'd0, exp_byte(4, 8'h01, cmd_word, seq_m)});
    rst_n = 1'b0; write_finish = 1'b1;
    @(negedge clk);
    write_finish = 1'b0;
    chk("abort_valid", {31'd0, app_tx_data_valid}, 32'd0);
    chk("abort_req", {31'd0, app_tx_data_request}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seq_m = 8'h00;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (app_tx_data_request === 1'b1 || app_tx_data_valid === 1'b1) seen = 1'b1;
    end
    chk("no_packet_after_rst", {31'd0, seen}, 32'd0);
    cmd_word = $urandom;
    pulse(1'b0, 1'b1);
    run_packet(8'h02, cmd_word, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
